// File: rtl/conv_tile_sequencer_if.sv
// Job config, feed/writeback handshakes and PE control of the conv tile sequencer.
// master = sequencer side, slave = SRAM banks / PE array / OFM sink / host side.
interface conv_tile_sequencer_if #(
    parameter int NUM_PE = 256,
    parameter int CH_W   = 8,
    parameter int TILE_W = 8,
    parameter int FILT_W = 8,
    parameter int HW_W   = 16,
    parameter int ADDR_W = 24
);
    logic              start;
    logic [CH_W-1:0]   cfg_in_ch;
    logic [TILE_W-1:0] cfg_num_tiles;
    logic [FILT_W-1:0] cfg_num_filt;
    logic [HW_W-1:0]   cfg_hw;
    logic              feed_valid;
    logic              feed_ready;
    logic [ADDR_W-1:0] ifm_addr;
    logic [ADDR_W-1:0] wgt_addr;
    logic [NUM_PE-1:0] pe_finish;
    logic [NUM_PE-1:0] pe_restart;
    logic              ofm_wr_en;
    logic              ofm_ready;
    logic [TILE_W-1:0] ofm_tile;
    logic [FILT_W-1:0] ofm_filt;
    logic              busy;
    logic              done;
    logic [31:0]       perf_cycles;

    modport master (
        input  start, cfg_in_ch, cfg_num_tiles, cfg_num_filt, cfg_hw, feed_ready, ofm_ready,
        output feed_valid, ifm_addr, wgt_addr, pe_finish, pe_restart,
               ofm_wr_en, ofm_tile, ofm_filt, busy, done, perf_cycles
    );

    modport slave (
        output start, cfg_in_ch, cfg_num_tiles, cfg_num_filt, cfg_hw, feed_ready, ofm_ready,
        input  feed_valid, ifm_addr, wgt_addr, pe_finish, pe_restart,
               ofm_wr_en, ofm_tile, ofm_filt, busy, done, perf_cycles
    );
endinterface

// File: rtl/conv_tile_sequencer.sv
// Walks filter -> tile -> channel -> kernel-pixel loops, feeding the PE array and requesting OFM writeback per tile.
// Latency: start accepted at cycle 0 -> finish pulse c1, restart c2, first feed beat c3; PE_LAT drain cycles per window.
// Backpressure: feed_ready low freezes feed counters/addresses; ofm_ready low holds WRITE with all outputs stable.
module conv_tile_sequencer #(
    parameter int NUM_PE = 256,
    parameter int K_PIX  = 9,
    parameter int CH_W   = 8,
    parameter int TILE_W = 8,
    parameter int FILT_W = 8,
    parameter int HW_W   = 16,
    parameter int ADDR_W = 24,
    parameter int PE_LAT = 2
) (
    input logic clk,
    input logic reset_n,
    conv_tile_sequencer_if.master bus
);
    localparam int P_W  = (K_PIX > 1) ? $clog2(K_PIX) : 1;
    localparam int DR_W = (PE_LAT > 1) ? $clog2(PE_LAT + 1) : 1;
    localparam logic [ADDR_W-1:0] A_KPIX = ADDR_W'(K_PIX);
    localparam logic [ADDR_W-1:0] A_TILE = ADDR_W'(NUM_PE * K_PIX);

    typedef enum logic [2:0] {IDLE, CLEAR, RESTART, FEED, DRAIN, WRITE, DONE} state_t;

    state_t            state, nxt;
    logic [P_W-1:0]    p;
    logic [CH_W-1:0]   c, ch_r;
    logic [TILE_W-1:0] t, tiles_r;
    logic [FILT_W-1:0] f, filt_r;
    logic [HW_W-1:0]   hw_r;
    logic [DR_W-1:0]   drain_cnt;
    logic [31:0]       perf;

    logic accept, cfg_empty, beat, wr_hs;
    logic last_pix, last_ch, last_tile, last_filt;
    logic feed_valid, finish_p, restart_p, wr_en, busy, done;
    logic [ADDR_W-1:0] ifm_full, wgt_full;

    assign accept    = (state == IDLE) && bus.start;
    assign cfg_empty = (bus.cfg_in_ch == '0) || (bus.cfg_num_tiles == '0) || (bus.cfg_num_filt == '0);
    assign beat      = (state == FEED) && bus.feed_ready;
    assign wr_hs     = (state == WRITE) && bus.ofm_ready;
    assign last_pix  = (p == P_W'(K_PIX - 1));
    assign last_ch   = (c == ch_r - CH_W'(1));
    assign last_tile = (t == tiles_r - TILE_W'(1));
    assign last_filt = (f == filt_r - FILT_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt        = state;
        feed_valid = 1'b0;
        finish_p   = 1'b0;
        restart_p  = 1'b0;
        wr_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (bus.start) nxt = cfg_empty ? DONE : CLEAR;
            CLEAR: begin
                busy     = 1'b1;
                finish_p = 1'b1;
                nxt      = RESTART;
            end
            RESTART: begin
                busy      = 1'b1;
                restart_p = 1'b1;
                nxt       = FEED;
            end
            FEED: begin
                busy       = 1'b1;
                feed_valid = 1'b1;
                if (bus.feed_ready && last_pix && last_ch) nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == DR_W'(PE_LAT - 1)) nxt = WRITE;
            end
            WRITE: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                if (bus.ofm_ready) nxt = (last_tile && last_filt) ? DONE : RESTART;
            end
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Loop counters; they all wrap back to zero on the final beat/write, so a finished job leaves them clean.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p         <= '0;
            c         <= '0;
            t         <= '0;
            f         <= '0;
            ch_r      <= '0;
            tiles_r   <= '0;
            filt_r    <= '0;
            hw_r      <= '0;
            drain_cnt <= '0;
        end else begin
            if (accept) begin
                ch_r    <= bus.cfg_in_ch;
                tiles_r <= bus.cfg_num_tiles;
                filt_r  <= bus.cfg_num_filt;
                hw_r    <= bus.cfg_hw;
                p       <= '0;
                c       <= '0;
                t       <= '0;
                f       <= '0;
            end else begin
                if (beat) begin
                    if (last_pix) begin
                        p <= '0;
                        c <= last_ch ? '0 : c + CH_W'(1);
                    end else begin
                        p <= p + P_W'(1);
                    end
                end
                if (wr_hs) begin
                    if (last_tile) begin
                        t <= '0;
                        f <= last_filt ? '0 : f + FILT_W'(1);
                    end else begin
                        t <= t + TILE_W'(1);
                    end
                end
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + DR_W'(1) : '0;
        end
    end

    // The accept cycle counts as the first cycle and the done cycle as the last one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                               perf <= '0;
        else if (accept)                            perf <= 32'd1;
        else if (state != IDLE && perf != '1)       perf <= perf + 32'd1;
    end

    assign ifm_full = ADDR_W'(p) + ADDR_W'(c) * A_KPIX * ADDR_W'(hw_r) + ADDR_W'(t) * A_TILE;
    assign wgt_full = ADDR_W'(p) + ADDR_W'(c) * A_KPIX + ADDR_W'(f) * A_KPIX * ADDR_W'(ch_r);

    assign bus.feed_valid  = feed_valid;
    assign bus.ifm_addr    = feed_valid ? ifm_full : '0;
    assign bus.wgt_addr    = feed_valid ? wgt_full : '0;
    assign bus.pe_finish   = {NUM_PE{finish_p}};
    assign bus.pe_restart  = {NUM_PE{restart_p}};
    assign bus.ofm_wr_en   = wr_en;
    assign bus.ofm_tile    = wr_en ? t : '0;
    assign bus.ofm_filt    = wr_en ? f : '0;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.perf_cycles = perf;
endmodule
